hub75_scan_driver: RTL

- Parametrised HUB75 LED-matrix scan driver for the Basys3 Pmod headers JB/JC.
- Replaces the fixed-pattern blanking test driver.
- Reads pixel pairs (top half, bottom half) from an external framebuffer over a 1-cycle-latency read port. Shifts each row into the panel with a divided pixel clock, then latches it and displays it for a programmable on-time.
- Iterates over all row addresses continuously while enabled.

---
 rtl/hub75_scan_driver_if.sv | 23 ++
 rtl/hub75_scan_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_driver_if.sv
// ---------------------------------------------------------------------------
// hub75_scan_driver_if
//   Framebuffer read port between the HUB75 scan driver and the pixel store.
//
//   Protocol: fixed-latency read with no valid/ready. The master presents
//   fb_addr = {row, col}; the slave returns the pixel pair on fb_data exactly
//   one clk later and keeps it stable until the following address is taken.
//
//   Signals:
//     fb_addr  ROW_BITS+COL_BITS  read address {row, col}      (master -> slave)
//     fb_data  6*COLOR_BITS       {R1,G1,B1,R0,G0,B0}, MSB first (slave -> master)
// ---------------------------------------------------------------------------
interface hub75_scan_driver_if #(
   parameter int ROW_BITS   = 4,
   parameter int COL_BITS   = 5,
   parameter int COLOR_BITS = 1
);
   logic [ROW_BITS+COL_BITS-1:0] fb_addr;
   logic [6*COLOR_BITS-1:0]      fb_data;

   modport master (output fb_addr, input fb_data);
   modport slave  (input fb_addr, output fb_data);
endinterface

// File: rtl/hub75_scan_driver.sv
// ---------------------------------------------------------------------------
// hub75_scan_driver
//   HUB75 LED-matrix scan driver (Basys3 Pmod JB/JC). Each row is fetched
//   pixel pair by pixel pair from a framebuffer, shifted out with a divided
//   pixel clock, latched, then displayed for a programmable on-time. Rows are
//   scanned continuously while enable is high; enable is only looked at in
//   IDLE and at the end of a frame.
//
//   Optional feature: define HUB75_BCM_EN for binary-coded modulation
//   (every row shifted once per bit plane, display time ON_TIME<<plane).
//   Without it only the channel MSB is shown, for ON_TIME cycles per row.
//
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     enable       run scanning
//     fb           framebuffer read port (master side)
//     frame_start  1-cycle pulse on the FETCH of row 0, first plane, col 0
//     JB           {R0,G0,B0,0,R1,G1,B1,0}
//     JC           {A0,A1,A2,A3,BL,LA,CK,A4}
//     dbgState     current FSM state, for observation only
// ---------------------------------------------------------------------------
module hub75_scan_driver #(
   parameter int COL_BITS   = 5,
   parameter int ROW_BITS   = 4,
   parameter int CLK_DIV    = 2,
   parameter int ON_TIME    = 64,
   parameter int COLOR_BITS = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   hub75_scan_driver_if.master        fb,
   output logic                       frame_start,
   output logic [7:0]                 JB,
   output logic [7:0]                 JC,
   output logic [2:0]                 dbgState
);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
`ifdef HUB75_BCM_EN
   localparam int DISP_MAX = ON_TIME << (COLOR_BITS - 1);
`else
   localparam int DISP_MAX = ON_TIME;
`endif
   localparam int DISP_W = $clog2(DISP_MAX + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CK_LOW, S_CK_HIGH, S_BLANK, S_LATCH, S_DISPLAY
   } state_t;

   state_t              state, stateNext;
   logic [ROW_BITS-1:0] row, rowNext;
   logic [COL_BITS-1:0] col, colNext;
   logic [DIV_W-1:0]    divCnt, divNext;
   logic [DISP_W-1:0]   dispCnt, dispNext, dispLast;
   logic [PLANE_W-1:0]  bitSel;
   logic                firstPlaneNext;

   // Output registers and their next values
   logic [ROW_BITS+COL_BITS-1:0] fbAddrQ, fbAddrD;
   logic                         frameStartQ, frameStartD;
   logic [5:0]                   rgbQ, rgbD;      // {R1,G1,B1,R0,G0,B0}
   logic                         ckQ, ckD, laQ, laD, blQ, blD;
   logic [ROW_BITS-1:0]          aQ, aD;

`ifdef HUB75_BCM_EN
   logic [PLANE_W-1:0] plane, planeNext;
   logic               lastPlane;
   assign bitSel         = plane;
   assign lastPlane      = (plane == PLANE_W'(COLOR_BITS - 1));
   assign firstPlaneNext = (planeNext == '0);
   assign dispLast       = DISP_W'((ON_TIME << plane) - 1);
`else
   // Single pass per row on the channel MSB.
   assign bitSel         = PLANE_W'(COLOR_BITS - 1);
   assign firstPlaneNext = 1'b1;
   assign dispLast       = DISP_W'(ON_TIME - 1);
`endif

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         row         <= '0;
         col         <= '0;
         divCnt      <= '0;
         dispCnt     <= '0;
`ifdef HUB75_BCM_EN
         plane       <= '0;
`endif
         fbAddrQ     <= '0;
         frameStartQ <= 1'b0;
         rgbQ        <= '0;
         ckQ         <= 1'b0;
         laQ         <= 1'b0;
         blQ         <= 1'b1;
         aQ          <= '0;
      end else begin
         state       <= stateNext;
         row         <= rowNext;
         col         <= colNext;
         divCnt      <= divNext;
         dispCnt     <= dispNext;
`ifdef HUB75_BCM_EN
         plane       <= planeNext;
`endif
         fbAddrQ     <= fbAddrD;
         frameStartQ <= frameStartD;
         rgbQ        <= rgbD;
         ckQ         <= ckD;
         laQ         <= laD;
         blQ         <= blD;
         aQ          <= aD;
      end
   end

   // Next state and counters
   always_comb begin
      stateNext = state;
      rowNext   = row;
      colNext   = col;
      divNext   = divCnt;
      dispNext  = dispCnt;
`ifdef HUB75_BCM_EN
      planeNext = plane;
`endif
      case (state)
         S_IDLE: begin
            if (enable) begin
               stateNext = S_FETCH;
               rowNext   = '0;
               colNext   = '0;
`ifdef HUB75_BCM_EN
               planeNext = '0;
`endif
            end
         end
         S_FETCH: begin
            stateNext = S_CK_LOW;
            divNext   = '0;
         end
         S_CK_LOW: begin
            if (divCnt == DIV_LAST) begin
               stateNext = S_CK_HIGH;
               divNext   = '0;
            end else begin
               divNext = divCnt + DIV_W'(1);
            end
         end
         S_CK_HIGH: begin
            if (divCnt == DIV_LAST) begin
               divNext = '0;
               if (&col) begin
                  colNext   = '0;
                  stateNext = S_BLANK;
               end else begin
                  colNext   = col + COL_BITS'(1);
                  stateNext = S_FETCH;
               end
            end else begin
               divNext = divCnt + DIV_W'(1);
            end
         end
         S_BLANK: stateNext = S_LATCH;
         S_LATCH: begin
            stateNext = S_DISPLAY;
            dispNext  = '0;
         end
         S_DISPLAY: begin
            if (dispCnt == dispLast) begin
               stateNext = S_FETCH;
`ifdef HUB75_BCM_EN
               if (!lastPlane) begin
                  planeNext = plane + PLANE_W'(1);
               end else begin
                  planeNext = '0;
`else
               begin
`endif
                  if (&row) begin
                     // Frame boundary: the only point enable is resampled.
                     rowNext = '0;
                     if (!enable) stateNext = S_IDLE;
                  end else begin
                     rowNext = row + ROW_BITS'(1);
                  end
               end
            end else begin
               dispNext = dispCnt + DISP_W'(1);
            end
         end
         default: stateNext = S_IDLE;
      endcase
   end

   // Output values are derived from the state being entered, so each
   // registered output is valid during the cycle of the state it belongs to.
   always_comb begin
      fbAddrD     = fbAddrQ;
      frameStartD = 1'b0;
      rgbD        = rgbQ;
      aD          = aQ;
      ckD         = (stateNext == S_CK_HIGH);
      laD         = (stateNext == S_LATCH);
      blD         = (stateNext != S_DISPLAY);
      if (stateNext == S_FETCH) begin
         fbAddrD     = {rowNext, colNext};
         frameStartD = (rowNext == '0) && (colNext == '0) && firstPlaneNext;
      end
      // fb_data answers the FETCH address during the first CK_LOW cycle.
      if (state == S_CK_LOW && divCnt == '0) begin
         for (int k = 0; k < 6; k++) begin
            rgbD[k] = fb.fb_data[k*COLOR_BITS + int'(bitSel)];
         end
      end
      if (stateNext == S_BLANK) begin
         rgbD = '0;
         aD   = row;
      end
      if (stateNext == S_IDLE) rgbD = '0;
   end

   logic [4:0] aPad;
   assign aPad        = 5'(aQ);
   assign fb.fb_addr  = fbAddrQ;
   assign frame_start = frameStartQ;
   assign JB          = {rgbQ[2], rgbQ[1], rgbQ[0], 1'b0, rgbQ[5], rgbQ[4], rgbQ[3], 1'b0};
   assign JC          = {aPad[0], aPad[1], aPad[2], aPad[3], blQ, laQ, ckQ, aPad[4]};
   assign dbgState    = state;
endmodule
